// File: rtl/uart_tx.sv
// UART transmitter: frames one byte per valid/ready handshake as start, 5-8 data bits LSB-first,
// optional parity and STOP_BITS stop bits. CSR layouts: control[3:0]=data_bits, [4]=odd_parity, [5]=parity_bit;
// status[0]=busy, [1]=data_bits_error, [2]=parity_error (always 0), rest 0.
module uart_tx #(
    parameter int unsigned CLK_FREQ_HZ = 100_000_000,
    parameter int unsigned STOP_BITS   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] baud_rate_csr,
    input  logic [31:0] control_csr,
    input  logic [7:0]  tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic        tx,
    output logic [31:0] status_csr
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_e;

    localparam logic [33:0] CLK_W     = 34'(CLK_FREQ_HZ);
    localparam logic [31:0] CLK_32    = 32'(CLK_FREQ_HZ);
    localparam logic [3:0]  LAST_STOP = 4'(STOP_BITS - 1);

    state_e      state_q, state_d;
    logic        tx_q, tx_d;
    logic        busy_q, busy_d;
    logic        dbits_err_q, dbits_err_d;
    logic [32:0] acc_q, acc_d;
    logic [7:0]  shift_q, shift_d;
    logic [3:0]  nbits_q, nbits_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic        par_en_q, par_en_d;
    logic        par_q, par_d;
    logic [31:0] eff_baud_q, eff_baud_d;

    logic        accept;
    logic [3:0]  csr_data_bits;
    logic        csr_legal;
    logic [3:0]  nbits_sel;
    logic [7:0]  data_mask;
    logic [7:0]  masked_data;
    logic [33:0] acc_sum;
    logic [33:0] acc_wrap;
    logic        tick;
    logic        unused_bits;

    assign accept        = tx_valid && tx_ready;
    assign csr_data_bits = control_csr[3:0];
    assign csr_legal     = (csr_data_bits >= 4'd5) && (csr_data_bits <= 4'd8);
    assign nbits_sel     = csr_legal ? csr_data_bits : 4'd8;
    assign data_mask     = 8'hFF >> (4'd8 - nbits_sel);
    assign masked_data   = tx_data & data_mask;

    // Fractional bit-rate accumulator: a tick each time the running sum crosses the clock frequency
    assign acc_sum  = {1'b0, acc_q} + {2'b00, eff_baud_q};
    assign acc_wrap = acc_sum - CLK_W;
    assign tick     = (acc_sum >= CLK_W);

    assign unused_bits = ^{control_csr[31:6], acc_wrap[33]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
            dbits_err_q <= 1'b0;
            acc_q       <= '0;
            shift_q     <= '0;
            nbits_q     <= 4'd8;
            bit_cnt_q   <= '0;
            par_en_q    <= 1'b0;
            par_q       <= 1'b0;
            eff_baud_q  <= '0;
        end else begin
            state_q     <= state_d;
            tx_q        <= tx_d;
            busy_q      <= busy_d;
            dbits_err_q <= dbits_err_d;
            acc_q       <= acc_d;
            shift_q     <= shift_d;
            nbits_q     <= nbits_d;
            bit_cnt_q   <= bit_cnt_d;
            par_en_q    <= par_en_d;
            par_q       <= par_d;
            eff_baud_q  <= eff_baud_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        tx_d        = tx_q;
        busy_d      = busy_q;
        dbits_err_d = dbits_err_q;
        acc_d       = acc_q;
        shift_d     = shift_q;
        nbits_d     = nbits_q;
        bit_cnt_d   = bit_cnt_q;
        par_en_d    = par_en_q;
        par_d       = par_q;
        eff_baud_d  = eff_baud_q;

        if (state_q != IDLE) begin
            acc_d = tick ? acc_wrap[32:0] : acc_sum[32:0];
        end

        case (state_q)
            IDLE: begin
                // Everything that shapes the frame is frozen here so CSR writes mid-frame are harmless
                if (accept) begin
                    shift_d     = masked_data;
                    nbits_d     = nbits_sel;
                    par_en_d    = control_csr[5];
                    par_d       = control_csr[4] ? ~^masked_data : ^masked_data;
                    eff_baud_d  = (baud_rate_csr > CLK_32) ? CLK_32 : baud_rate_csr;
                    dbits_err_d = !csr_legal;
                    acc_d       = '0;
                    tx_d        = 1'b0;
                    busy_d      = 1'b1;
                    state_d     = START;
                end
            end
            START: begin
                if (tick) begin
                    state_d   = DATA;
                    tx_d      = shift_q[0];
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_cnt_q == nbits_q - 4'd1) begin
                        bit_cnt_d = '0;
                        if (par_en_q) begin
                            state_d = PARITY;
                            tx_d    = par_q;
                        end else begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    state_d   = STOP;
                    tx_d      = 1'b1;
                    bit_cnt_d = '0;
                end
            end
            STOP: begin
                if (tick) begin
                    if (bit_cnt_q == LAST_STOP) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_comb begin
        tx_ready   = (state_q == IDLE) && (baud_rate_csr != 32'd0);
        tx         = tx_q;
        status_csr = {29'd0, 1'b0, dbits_err_q, busy_q};
    end

endmodule
